// File: rtl/jtframe_bcd2bin_pkg.sv
// jtframe_bcd2bin_pkg: BCD digit constants and result-width helper for BCD blocks.
package jtframe_bcd2bin_pkg;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Smallest result width able to hold 10^digits-1.
    function automatic int min_bw(input int digits);
        longint v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return $clog2(v);
    endfunction
endpackage

// File: rtl/jtframe_bcd2bin.sv
// jtframe_bcd2bin: sequential BCD to binary converter, one digit per clock, MSD first.
module jtframe_bcd2bin
    import jtframe_bcd2bin_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BW     = 14
)(
    input  logic                rst,
    input  logic                clk,
    input  logic                start,
    input  logic [DIGITS*4-1:0] bcd,
    output logic                busy,
    output logic                done,
    output logic [BW-1:0]       bin,
    output logic                err
);
    localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic                r_busy, r_done, r_err, r_eflag;
    logic [BW-1:0]       r_bin, r_acc;
    logic [CW-1:0]       r_cnt;
    logic [DIGITS*4-1:0] r_sr;
    logic [3:0]          w_d;
    logic [BW-1:0]       w_acc_nx;
    logic                w_eflag;

    assign w_d      = r_sr[DIGITS*4-1 -: 4];
    // Invalid digits are accumulated raw; only the error flag reports them.
    assign w_acc_nx = (r_acc << 3) + (r_acc << 1) + BW'(w_d);
    assign w_eflag  = r_eflag | (w_d > DIGIT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= '0;
            r_err   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_eflag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (start) begin
                    r_busy  <= 1'b1;
                    r_sr    <= bcd;
                    r_acc   <= '0;
                    r_cnt   <= CW'(DIGITS - 1);
                    r_eflag <= 1'b0;
                end
            end else begin
                r_acc   <= w_acc_nx;
                r_sr    <= r_sr << 4;
                r_eflag <= w_eflag;
                r_cnt   <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_bin  <= w_acc_nx;
                    r_err  <= w_eflag;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bin  = r_bin;
    assign err  = r_err;
endmodule

// File: tb/tb_jtframe_bcd2bin.sv
// tb_jtframe_bcd2bin: randomized checks of three converter sizes against an arithmetic model.
module tb_jtframe_bcd2bin;
    logic        clk = 1'b0, rst = 1'b1;
    logic        st4 = 1'b0, st8 = 1'b0, st1 = 1'b0;
    logic [15:0] bcd4 = '0;
    logic [31:0] bcd8 = '0;
    logic [3:0]  bcd1 = '0;
    logic        busy4, done4, err4, busy8, done8, err8, busy1, done1, err1;
    logic [13:0] bin4;
    logic [26:0] bin8;
    logic [3:0]  bin1;
    int          vecs = 0, errs = 0;
    int          sel = 4;
    logic        m_busy, m_done, m_err;
    logic [31:0] m_bin;

    always #5 clk = ~clk;

    jtframe_bcd2bin #(.DIGITS(4), .BW(14)) u4 (.rst(rst), .clk(clk), .start(st4), .bcd(bcd4),
        .busy(busy4), .done(done4), .bin(bin4), .err(err4));
    jtframe_bcd2bin #(.DIGITS(8), .BW(27)) u8 (.rst(rst), .clk(clk), .start(st8), .bcd(bcd8),
        .busy(busy8), .done(done8), .bin(bin8), .err(err8));
    jtframe_bcd2bin #(.DIGITS(1), .BW(4)) u1 (.rst(rst), .clk(clk), .start(st1), .bcd(bcd1),
        .busy(busy1), .done(done1), .bin(bin1), .err(err1));

    always_comb begin
        m_busy = sel == 8 ? busy8 : sel == 1 ? busy1 : busy4;
        m_done = sel == 8 ? done8 : sel == 1 ? done1 : done4;
        m_err  = sel == 8 ? err8  : sel == 1 ? err1  : err4;
        m_bin  = sel == 8 ? 32'(bin8) : sel == 1 ? 32'(bin1) : 32'(bin4);
    end

    function automatic void ref_conv(input logic [31:0] v, input int nd, input int bw,
                                     output longint val, output logic e);
        longint p;
        logic [3:0] dg;
        val = 0; p = 1; e = 1'b0;
        for (int i = 0; i < nd; i++) begin
            dg = v[i*4 +: 4];
            val += longint'(dg) * p;
            p *= 10;
            e |= dg > 4'd9;
        end
        val = val % (longint'(1) << bw);
    endfunction

    task automatic drive(input logic s, input logic [31:0] v);
        if (sel == 8) begin st8 = s; bcd8 = v; end
        else if (sel == 1) begin st1 = s; bcd1 = v[3:0]; end
        else begin st4 = s; bcd4 = v[15:0]; end
    endtask

    task automatic run(input int s, input logic [31:0] v);
        int c, nb, bw;
        longint ev;
        logic ee;
        logic [31:0] hold;
        sel = s;
        bw = s == 8 ? 27 : s == 1 ? 4 : 14;
        ref_conv(v, s, bw, ev, ee);
        @(negedge clk);
        hold = m_bin;
        drive(1'b1, v);
        @(negedge clk);
        drive(1'b0, $urandom);
        c = 1; nb = 0;
        while (!m_done && c < 40) begin
            if (m_busy) nb++;
            vecs++;
            if (m_bin !== hold) begin errs++; $display("FAIL hold d%0d: bin=%0d want %0d", s, m_bin, hold); end
            @(negedge clk); c++;
        end
        vecs += 5;
        if (c != s + 1) begin errs++; $display("FAIL latency d%0d v=%h: %0d cycles want %0d", s, v, c, s + 1); end
        if (nb != s) begin errs++; $display("FAIL busy_len d%0d: %0d want %0d", s, nb, s); end
        if (m_bin !== 32'(ev)) begin errs++; $display("FAIL bin d%0d v=%h: %0d want %0d", s, v, m_bin, ev); end
        if (m_err !== ee) begin errs++; $display("FAIL err d%0d v=%h: %b want %b", s, v, m_err, ee); end
        if (m_busy !== 1'b0) begin errs++; $display("FAIL busy_at_done d%0d: %b want 0", s, m_busy); end
        @(negedge clk);
        vecs++;
        if (m_done !== 1'b0) begin errs++; $display("FAIL done_pulse d%0d: %b want 0", s, m_done); end
    endtask

    task automatic test_reset;
        vecs += 4;
        if (busy4 !== 1'b0) begin errs++; $display("FAIL rst_busy: %b want 0", busy4); end
        if (done4 !== 1'b0) begin errs++; $display("FAIL rst_done: %b want 0", done4); end
        if (bin4 !== 14'd0) begin errs++; $display("FAIL rst_bin: %0d want 0", bin4); end
        if (err4 !== 1'b0) begin errs++; $display("FAIL rst_err: %b want 0", err4); end
    endtask

    task automatic test_directed;
        run(4, 32'h1234); run(4, 32'h9999); run(4, 32'h0000);
        run(4, 32'h12A4); run(4, 32'h0042); run(4, 32'hFFFF);
    endtask

    task automatic test_random;
        logic [31:0] v;
        for (int i = 0; i < 30; i++) begin
            v = $urandom;
            if (i % 2 == 0) for (int k = 0; k < 4; k++) v[k*4 +: 4] = 4'($urandom_range(9));
            run(4, v);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        sel = 4;
        @(negedge clk); st4 = 1'b1; bcd4 = 16'h0500;
        @(negedge clk); c = 1;
        while (!done4 && c < 20) begin
            st4 = ~st4; bcd4 = 16'h9999;
            @(negedge clk); c++;
        end
        vecs += 2;
        if (c != 5) begin errs++; $display("FAIL b2b_first_lat: %0d want 5", c); end
        if (bin4 !== 14'd500) begin errs++; $display("FAIL b2b_first_bin: %0d want 500", bin4); end
        st4 = 1'b1; bcd4 = 16'h0007;
        @(negedge clk); st4 = 1'b0; c = 1;
        while (!done4 && c < 20) begin @(negedge clk); c++; end
        vecs += 2;
        if (c != 5) begin errs++; $display("FAIL b2b_second_lat: %0d want 5", c); end
        if (bin4 !== 14'd7) begin errs++; $display("FAIL b2b_second_bin: %0d want 7", bin4); end
    endtask

    task automatic test_reset_mid;
        logic saw;
        run(4, 32'h1234);
        @(negedge clk); st4 = 1'b1; bcd4 = 16'h5678;
        @(negedge clk); st4 = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        vecs += 4;
        if (busy4 !== 1'b0) begin errs++; $display("FAIL midrst_busy: %b want 0", busy4); end
        if (bin4 !== 14'd0) begin errs++; $display("FAIL midrst_bin: %0d want 0", bin4); end
        if (err4 !== 1'b0) begin errs++; $display("FAIL midrst_err: %b want 0", err4); end
        if (done4 !== 1'b0) begin errs++; $display("FAIL midrst_done: %b want 0", done4); end
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); saw |= done4; end
        vecs += 2;
        if (saw !== 1'b0) begin errs++; $display("FAIL midrst_nodone: saw done=%b want 0", saw); end
        if (bin4 !== 14'd0) begin errs++; $display("FAIL midrst_bin_after: %0d want 0", bin4); end
    endtask

    task automatic test_sizes;
        logic [31:0] v;
        run(8, 32'h99999999);
        for (int i = 0; i < 6; i++) begin
            v = '0;
            for (int k = 0; k < 8; k++) v[k*4 +: 4] = 4'($urandom_range(i == 5 ? 15 : 9));
            run(8, v);
        end
        run(1, 32'h7);
        for (int i = 0; i < 6; i++) run(1, 32'($urandom_range(15)));
    endtask

    task automatic test_single_held;
        sel = 1;
        @(negedge clk); st1 = 1'b1; bcd1 = 4'h7;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vecs++;
            if (done1 !== (c % 2 == 0)) begin errs++; $display("FAIL held_d1 c=%0d: done=%b want %b", c, done1, c % 2 == 0); end
        end
        st1 = 1'b0;
        vecs++;
        if (bin1 !== 4'd7) begin errs++; $display("FAIL held_d1_bin: %0d want 7", bin1); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_sizes;
        test_single_held;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
